// File: rtl/button_pkg.sv
// Shared types and widths for the button pulser and its hold timer.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } state_e;

    localparam int CNT_W  = 20;
    localparam int PCNT_W = 8;

endpackage

// File: rtl/hold_timer.sv
// Clearable 20-bit cycle counter with a terminal-count compare against limit_i.
module hold_timer
    import button_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == limit_i);

endmodule

// File: rtl/button_pulser.sv
// Turns a debounced button level into press/repeat/release strobes and a press count.
// Auto-repeat is built only when BUTTON_PULSER_REPEAT_EN is defined.
module button_pulser
    import button_pkg::*;
#(
    parameter int HOLD_DELAY    = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              cleanclk_i,
    output logic              pulse_o,
    output logic              release_o,
    output logic              held_o,
    output logic [PCNT_W-1:0] press_count_o
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_PERIOD - 1);

    state_e            state_q;
    logic              pulse_q;
    logic              release_q;
    logic              held_q;
    logic [PCNT_W-1:0] count_q;

    logic             timer_clear;
    logic             timer_enable;
    logic             timer_done;
    logic [CNT_W-1:0] timer_limit;

    always_comb begin
        timer_limit = (state_q == REPEAT) ? REP_LIM : HOLD_LIM;
`ifdef BUTTON_PULSER_REPEAT_EN
        timer_clear  = (state_q == IDLE) || !cleanclk_i || timer_done;
        timer_enable = 1'b1;
`else
        // Without repeat the count parks at its terminal value for the rest of the hold.
        timer_clear  = (state_q == IDLE) || !cleanclk_i;
        timer_enable = !timer_done;
`endif
    end

    hold_timer u_hold_timer (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .limit_i   (timer_limit),
        .done_o    (timer_done)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cleanclk_i) begin
                        pulse_q <= 1'b1;
                        count_q <= count_q + PCNT_W'(1);
                        held_q  <= 1'b1;
                        state_q <= PRESSED;
                    end else begin
                        held_q  <= 1'b0;
                    end
                end
                PRESSED: begin
                    if (!cleanclk_i) begin
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        held_q    <= 1'b1;
`ifdef BUTTON_PULSER_REPEAT_EN
                        if (timer_done) begin
                            pulse_q <= 1'b1;
                            count_q <= count_q + PCNT_W'(1);
                            state_q <= REPEAT;
                        end
`endif
                    end
                end
`ifdef BUTTON_PULSER_REPEAT_EN
                REPEAT: begin
                    if (!cleanclk_i) begin
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        held_q    <= 1'b1;
                        if (timer_done) begin
                            pulse_q <= 1'b1;
                            count_q <= count_q + PCNT_W'(1);
                        end
                    end
                end
`endif
                default: begin
                    held_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pulse_o       = pulse_q;
    assign release_o     = release_q;
    assign held_o        = held_q;
    assign press_count_o = count_q;

endmodule

// File: tb/tb_button_pulser.sv
// Self-checking bench for button_pulser: hold-length model plus directed and random presses.
module tb_button_pulser;

    localparam int HD = 10;
    localparam int RP = 4;
`ifdef BUTTON_PULSER_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       clean = 1'b0;
    logic       pulse;
    logic       rel;
    logic       held;
    logic [7:0] pc;

    always #5 clk = ~clk;

    button_pulser #(
        .HOLD_DELAY    (HD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clock_i       (clk),
        .reset_n_i     (rstn),
        .cleanclk_i    (clean),
        .pulse_o       (pulse),
        .release_o     (rel),
        .held_o        (held),
        .press_count_o (pc)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Inputs as seen by the DUT on the latest rising edge.
    logic s_clean = 1'b0;
    logic s_rstn  = 1'b0;
    always @(posedge clk) begin
        s_clean <= clean;
        s_rstn  <= rstn;
    end

    // Model: k is the index of the current sample within an unbroken hold (-1 = not held).
    bit started  = 1'b0;
    int cyc      = 0;
    int pq[$];
    int rel_cnt  = 0;
    int held_cnt = 0;

    initial begin
        int  k   = -1;
        bit  ep  = 1'b0;
        bit  er  = 1'b0;
        bit  eh  = 1'b0;
        int  epc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!s_rstn) begin
                ep = 0; er = 0; eh = 0; epc = 0; k = -1;
            end else if (s_clean) begin
                k++;
                ep = (k == 0) || (REP_EN && k >= HD && ((k - HD) % RP) == 0);
                er = 0;
                eh = 1;
                if (ep) epc = (epc + 1) % 256;
            end else begin
                er = (k >= 0);
                ep = 0;
                eh = 0;
                k  = -1;
            end
            if (started) begin
                $display("cyc %0d rstn=%0b clean=%0b pulse=%0b release=%0b held=%0b count=%0d",
                         cyc, s_rstn, s_clean, pulse, rel, held, pc);
                chk("pulse", 32'(pulse), 32'(ep));
                chk("release", 32'(rel), 32'(er));
                chk("held", 32'(held), 32'(eh));
                chk("press_count", 32'(pc), 32'(epc));
                chk("overlap", 32'(pulse & rel), 32'd0);
            end
            if (pulse === 1'b1) pq.push_back(cyc);
            if (rel === 1'b1) rel_cnt++;
            if (held === 1'b1) held_cnt++;
        end
    end

    task automatic drive(input logic c, input logic r, input int n);
        repeat (n) begin
            clean = c;
            rstn  = r;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        pq.delete();
        rel_cnt  = 0;
        held_cnt = 0;
    endtask

    initial begin
        int exp_pos[$];
        drive(1'b0, 1'b0, 2);
        started = 1'b1;
        settle();
        chk("reset_count", 32'(pc), 32'd0);
        chk("reset_held", 32'(held), 32'd0);
        chk("reset_pulse", 32'(pulse), 32'd0);
        chk("reset_release", 32'(rel), 32'd0);

        // Reset held while the button is down: no pulse may appear.
        clear_obs();
        drive(1'b1, 1'b0, 3);
        settle();
        chk("rst_hold_pulses", 32'(pq.size()), 32'd0);

        // Short press of 5 cycles.
        drive(1'b0, 1'b0, 1);
        clear_obs();
        drive(1'b1, 1'b1, 5);
        drive(1'b0, 1'b1, 1);
        settle();
        chk("short_pulses", 32'(pq.size()), 32'd1);
        chk("short_held", 32'(held_cnt), 32'd5);
        chk("short_release", 32'(rel_cnt), 32'd1);
        chk("short_count", 32'(pc), 32'd1);

        // Long hold of 30 cycles.
        drive(1'b0, 1'b0, 1);
        clear_obs();
        drive(1'b1, 1'b1, 30);
        drive(1'b0, 1'b1, 1);
        settle();
        if (REP_EN) exp_pos = '{0, 10, 14, 18, 22, 26};
        else        exp_pos = '{0};
        chk("long_pulses", 32'(pq.size()), 32'(exp_pos.size()));
        for (int i = 0; i < exp_pos.size() && i < pq.size(); i++)
            chk($sformatf("long_pos%0d", i), 32'(pq[i] - pq[0]), 32'(exp_pos[i]));
        chk("long_count", 32'(pc), 32'(exp_pos.size()));
        chk("long_release", 32'(rel_cnt), 32'd1);

        // Release lands exactly where the first repeat would be due.
        drive(1'b0, 1'b0, 1);
        clear_obs();
        drive(1'b1, 1'b1, HD);
        drive(1'b0, 1'b1, 1);
        settle();
        chk("collide_pulses", 32'(pq.size()), 32'd1);
        chk("collide_release", 32'(rel_cnt), 32'd1);
        chk("collide_count", 32'(pc), 32'd1);

        // 256 single-cycle presses wrap the counter.
        drive(1'b0, 1'b0, 1);
        clear_obs();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, 1);
            drive(1'b0, 1'b1, 1);
        end
        settle();
        chk("wrap_count", 32'(pc), 32'd0);
        chk("wrap_pulses", 32'(pq.size()), 32'd256);
        chk("wrap_release", 32'(rel_cnt), 32'd256);

        // Reset in the middle of a hold, button stays down.
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b1, 12);
        drive(1'b1, 1'b0, 1);
        settle();
        chk("midrst_count", 32'(pc), 32'd0);
        chk("midrst_held", 32'(held), 32'd0);
        chk("midrst_pulse", 32'(pulse), 32'd0);
        drive(1'b1, 1'b1, 1);
        settle();
        chk("midrst_newpulse", 32'(pulse), 32'd1);
        chk("midrst_newcount", 32'(pc), 32'd1);
        drive(1'b0, 1'b1, 2);

        // Random press/release/reset traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0)
                drive(1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, 2));
            drive(1'b1, 1'b1, $urandom_range(1, 40));
            drive(1'b0, 1'b1, $urandom_range(1, 4));
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
